// File: rtl/dds_rx_pkg.sv
// Shared constants, state encoding and lane helper for the DDS quadrature receiver.
package dds_rx_pkg;

  localparam int LANES  = 8;
  localparam int SMP_W  = 16;
  localparam int PROD_W = 2 * SMP_W;
  localparam int SUM_W  = PROD_W + 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic signed [SMP_W-1:0] lane_sel(
    input logic [LANES*SMP_W-1:0] bus,
    input int                     k
  );
    return bus[k*SMP_W +: SMP_W];
  endfunction

endpackage

// File: rtl/dds_lane_mac.sv
// One channel of the mixer: 8 lane multipliers feeding a registered 3-level adder tree.
// NEG=1 negates every product (used for the quadrature channel).
module dds_lane_mac
  import dds_rx_pkg::*;
#(
  parameter bit NEG = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic [LANES*SMP_W-1:0]  smp,
  input  logic [LANES*SMP_W-1:0]  ref_bus,
  output logic signed [SUM_W-1:0] sum,
  output logic                    sum_vld,
  output logic                    sum_last
);

  localparam int PAIR_W = PROD_W + 1;
  localparam int QUAD_W = PROD_W + 2;

  logic [LANES*SMP_W-1:0]   smp_p0;
  logic [LANES*SMP_W-1:0]   ref_p0;
  logic signed [PROD_W-1:0] prod_p1 [LANES];
  logic signed [PAIR_W-1:0] pair_p2 [LANES/2];
  logic signed [QUAD_W-1:0] quad_p3 [LANES/4];
  logic signed [SUM_W-1:0]  sum_p4;

  logic vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic last_p0, last_p1, last_p2, last_p3, last_p4;

  // Products always fit in PROD_W, including the negated -32768*-32768 case.
  function automatic logic signed [PROD_W-1:0] mix(
    input logic signed [SMP_W-1:0] a,
    input logic signed [SMP_W-1:0] b
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return NEG ? -p : p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vld_p0, vld_p1, vld_p2, vld_p3, vld_p4}      <= '0;
      {last_p0, last_p1, last_p2, last_p3, last_p4} <= '0;
    end else if (flush) begin
      {vld_p0, vld_p1, vld_p2, vld_p3, vld_p4}      <= '0;
      {last_p0, last_p1, last_p2, last_p3, last_p4} <= '0;
    end else begin
      vld_p0  <= in_vld;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      vld_p4  <= vld_p3;
      last_p0 <= in_last;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
      last_p3 <= last_p2;
      last_p4 <= last_p3;
    end
  end

  always_ff @(posedge clk) begin
    // p0: input capture
    smp_p0 <= smp;
    ref_p0 <= ref_bus;
    // p1: lane products
    for (int k = 0; k < LANES; k++)
      prod_p1[k] <= mix(lane_sel(smp_p0, k), lane_sel(ref_p0, k));
    // p2: pair sums
    for (int k = 0; k < LANES/2; k++)
      pair_p2[k] <= PAIR_W'(prod_p1[2*k]) + PAIR_W'(prod_p1[2*k+1]);
    // p3: quad sums
    for (int k = 0; k < LANES/4; k++)
      quad_p3[k] <= QUAD_W'(pair_p2[2*k]) + QUAD_W'(pair_p2[2*k+1]);
    // p4: lane sum
    sum_p4 <= SUM_W'(quad_p3[0]) + SUM_W'(quad_p3[1]);
  end

  assign sum      = sum_p4;
  assign sum_vld  = vld_p4;
  assign sum_last = last_p4;

endmodule

// File: rtl/dds_demod_rx.sv
// Quadrature integrate-and-dump receiver: mixes ADC lanes with the DDS I/Q reference.
// Define DDS_DEMOD_SAT_EN to saturate the output and enable the sticky overflow flag.
module dds_demod_rx
  import dds_rx_pkg::*;
#(
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [15:0]             dec_len,
  input  logic [LANES*SMP_W-1:0]  adc_data,
  input  logic                    adc_valid,
  input  logic [LANES*SMP_W-1:0]  dds_i,
  input  logic [LANES*SMP_W-1:0]  dds_q,
  input  logic                    dds_valid,
  output logic signed [OUT_W-1:0] bb_i,
  output logic signed [OUT_W-1:0] bb_q,
  output logic                    bb_valid,
  output logic                    overflow
);

  state_t state, state_nxt;

  logic [15:0] cnt;
  logic [15:0] len_r;
  logic        start, abort, beat, last_beat;

  logic signed [SUM_W-1:0] sum_i, sum_q;
  logic                    vld_i, vld_q, last_i, last_q;
  logic                    sum_vld, sum_last, dump_fire;
  logic signed [ACC_W-1:0] acc_i, acc_q, dump_i, dump_q;

  function automatic logic [15:0] fix_len(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

`ifdef DDS_DEMOD_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] shape(input logic signed [ACC_W-1:0] d);
    logic signed [ACC_W-1:0] s;
    s = d >>> OUT_SHIFT;
    if (s > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (s < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return s[OUT_W-1:0];
  endfunction

  function automatic logic clips(input logic signed [ACC_W-1:0] d);
    logic signed [ACC_W-1:0] s;
    s = d >>> OUT_SHIFT;
    return (s > OUT_MAX) || (s < OUT_MIN);
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] shape(input logic signed [ACC_W-1:0] d);
    return OUT_W'(d >>> OUT_SHIFT);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = ACCUM;
      ACCUM:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start     = (state == IDLE) && enable;
  assign abort     = (state == ACCUM) && !enable;
  assign beat      = (state == ACCUM) && enable && adc_valid && dds_valid;
  assign last_beat = beat && (cnt == len_r - 16'd1);

  // The period length is re-latched as its final beat is tagged, so a new
  // dec_len only takes effect for the period that follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      len_r <= 16'd1;
    end else if (start) begin
      cnt   <= '0;
      len_r <= fix_len(dec_len);
    end else if (last_beat) begin
      cnt   <= '0;
      len_r <= fix_len(dec_len);
    end else if (beat) begin
      cnt   <= cnt + 16'd1;
    end
  end

  dds_lane_mac #(.NEG(1'b0)) u_mac_i (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_vld   (beat),
    .in_last  (last_beat),
    .smp      (adc_data),
    .ref_bus  (dds_i),
    .sum      (sum_i),
    .sum_vld  (vld_i),
    .sum_last (last_i)
  );

  dds_lane_mac #(.NEG(1'b1)) u_mac_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_vld   (beat),
    .in_last  (last_beat),
    .smp      (adc_data),
    .ref_bus  (dds_q),
    .sum      (sum_q),
    .sum_vld  (vld_q),
    .sum_last (last_q)
  );

  assign sum_vld   = vld_i && vld_q;
  assign sum_last  = last_i && last_q;
  assign dump_i    = acc_i + ACC_W'(sum_i);
  assign dump_q    = acc_q + ACC_W'(sum_q);
  assign dump_fire = sum_vld && sum_last && !abort && !start;

  // p5: accumulate, or dump and reload with zero in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i    <= '0;
      acc_q    <= '0;
      bb_i     <= '0;
      bb_q     <= '0;
      bb_valid <= 1'b0;
    end else begin
      bb_valid <= 1'b0;
      if (abort || start) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (dump_fire) begin
        acc_i    <= '0;
        acc_q    <= '0;
        bb_i     <= shape(dump_i);
        bb_q     <= shape(dump_q);
        bb_valid <= 1'b1;
      end else if (sum_vld) begin
        acc_i <= dump_i;
        acc_q <= dump_q;
      end
    end
  end

`ifdef DDS_DEMOD_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (dump_fire && (clips(dump_i) || clips(dump_q)))
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dds_demod_rx.sv
// Scoreboard bench for dds_demod_rx: directed beats push expected dumps, a monitor checks strobes.
`timescale 1ns/1ps
module tb_dds_demod_rx;
  import dds_rx_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [15:0]             dec_len;
  logic [LANES*SMP_W-1:0]  adc_data, dds_i, dds_q;
  logic                    adc_valid, dds_valid;
  logic signed [31:0]      bb_i, bb_q;
  logic                    bb_valid, overflow;

  always #5 clk = ~clk;

  dds_demod_rx dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .dec_len   (dec_len),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .dds_i     (dds_i),
    .dds_q     (dds_q),
    .dds_valid (dds_valid),
    .bb_i      (bb_i),
    .bb_q      (bb_q),
    .bb_valid  (bb_valid),
    .overflow  (overflow)
  );

  typedef struct {
    logic signed [63:0] ei;
    logic signed [63:0] eq;
    int                 ecyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   strobes = 0;

`ifdef DDS_DEMOD_SAT_EN
  localparam logic signed [63:0] EXP_FS = 64'sd2147483647;
  localparam logic signed [63:0] EXP_OV = 64'sd1;
`else
  localparam logic signed [63:0] EXP_FS = -64'sd536862720;
  localparam logic signed [63:0] EXP_OV = 64'sd0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bb_valid) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("bb_i", bb_i, mon_e.ei);
        chk("bb_q", bb_q, mon_e.eq);
        chk("strobe_cycle", cyc, mon_e.ecyc);
      end
    end
  end

  task automatic set_data(input logic signed [15:0] a, input logic signed [15:0] di,
                          input logic signed [15:0] dq);
    adc_data = {LANES{a}};
    dds_i    = {LANES{di}};
    dds_q    = {LANES{dq}};
  endtask

  // Called on a negedge; the dump of a last beat appears 6 edges later.
  task automatic drive(input logic en, input logic av, input logic dv, input bit last,
                       input logic signed [63:0] ei, input logic signed [63:0] eq);
    enable    = en;
    adc_valid = av;
    dds_valid = dv;
    if (last) sb.push_back('{ei, eq, cyc + 6});
    @(negedge clk);
  endtask

  task automatic start(input logic [15:0] len);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    dec_len = len;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    adc_valid = 1'b0;
    dds_valid = 1'b0;
    while (sb.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; dds_valid = 1'b0; dec_len = 16'd4;
    set_data(0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_bb_i", bb_i, 0);
    chk("rst_bb_q", bb_q, 0);
    chk("rst_bb_valid", bb_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", dut.state, IDLE);

    // Valid data while disabled must not produce strobes
    set_data(1000, 16384, 0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("idle_strobes", strobes, 0);

    // In-phase, 4-beat periods, continuous valids
    start(16'd4);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b1, (i % 4) == 3, 64'sd524288000, 0);
    drain();

    // Quadrature, adc_valid every other cycle
    set_data(1000, 0, 16384);
    start(16'd4);
    for (int i = 0; i < 16; i++)
      drive(1'b1, (i % 2) == 0, 1'b1, ((i % 2) == 0) && ((i / 2) % 4 == 3), 0, -64'sd524288000);
    drain();

    // dec_len=0 behaves as 1: one dump per beat
    set_data(1000, 16384, 0);
    start(16'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 64'sd131072000, 0);
    for (int k = 0; k < LANES; k++) begin
      adc_data[k*SMP_W +: SMP_W] = 16'((k + 1) * 100);
      dds_i[k*SMP_W +: SMP_W]    = 16'd16384;
      dds_q[k*SMP_W +: SMP_W]    = 16'(k * 1000);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'sd58982400, -64'sd16800000);
    set_data(-1000, 16384, -16384);
    drive(1'b1, 1'b1, 1'b1, 1'b1, -64'sd131072000, -64'sd131072000);
    drain();

    // dec_len 4->2 during a period: current period still takes 4 beats
    set_data(1000, 16384, 0);
    start(16'd4);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) dec_len = 16'd2;
      drive(1'b1, 1'b1, 1'b1, (i == 3) || (i == 5) || (i == 7),
            (i == 3) ? 64'sd524288000 : 64'sd262144000, 0);
    end
    drain();

    // Abort after 2 of 4 beats, then a full fresh 4-beat period
    start(16'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    s0 = strobes;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("abort_no_strobe", strobes, s0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, i == 3, 64'sd524288000, 0);
    drain();

    // Full-scale 1024-beat period
    set_data(32767, 32767, 0);
    start(16'd1024);
    for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1, 1'b1, i == 1023, EXP_FS, 0);
    drain();
    chk("fullscale_overflow", overflow, EXP_OV);

    // Asynchronous reset mid-period
    set_data(1000, 16384, 0);
    start(16'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_bb_i", bb_i, 0);
    chk("arst_bb_q", bb_q, 0);
    chk("arst_bb_valid", bb_valid, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_state", dut.state, IDLE);
    enable = 1'b0; adc_valid = 1'b0; dds_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Recovery after reset
    start(16'd4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, i == 3, 64'sd524288000, 0);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
